// File: rtl/intr_pkg.sv
// Shared types and defaults for the interrupt controller.
package intr_pkg;

  localparam int unsigned NumSrcDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StWaitAck,
    StClear
  } intr_state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-facing signal bundle of the interrupt controller.
interface interrupt_controller_if #(
  parameter int unsigned NUM_SRC = intr_pkg::NumSrcDefault,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
);

  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] irq_mask;
  logic               int_ack;
  logic               intr;
  logic [ID_W-1:0]    int_id;
  logic [NUM_SRC-1:0] pending;

  modport master (
    input  irq_in,
    input  irq_mask,
    input  int_ack,
    output intr,
    output int_id,
    output pending
  );

  modport slave (
    output irq_in,
    output irq_mask,
    output int_ack,
    input  intr,
    input  int_id,
    input  pending
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one interrupt line plus a rising-edge detector.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  // edge_q resets low so a line held high across reset release reads as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~edge_q;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller: pending flags, fixed lowest-index priority, ack handshake.
module interrupt_controller
  import intr_pkg::*;
#(
  parameter int unsigned NUM_SRC = NumSrcDefault,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input logic                     clk,
  input logic                     rst,
  interrupt_controller_if.master  bus_io
);

  intr_state_e        state_q, state_d;
  logic               intr_q, intr_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] req;
  logic [ID_W-1:0]    sel_id;
  logic               clr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_i  (bus_io.irq_in[g]),
      .rise_o (rise[g])
    );
  end

  assign req = pending_q & bus_io.irq_mask;

  // Lowest set index wins.
  always_comb begin
    sel_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    intr_d   = 1'b0;
    int_id_d = int_id_q;
    clr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d  = StAssert;
          intr_d   = 1'b1;
          int_id_d = sel_id;
        end
      end
      StAssert: state_d = StWaitAck;
      StWaitAck: begin
        if (bus_io.int_ack) begin
          clr     = 1'b1;
          state_d = StClear;
        end
      end
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Clear first, then OR in new edges so a coincident edge keeps the flag set.
  always_comb begin
    pending_d = pending_q;
    if (clr) begin
      pending_d[int_id_q] = 1'b0;
    end
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      intr_q    <= 1'b0;
      int_id_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      intr_q    <= intr_d;
      int_id_q  <= int_id_d;
      pending_q <= pending_d;
    end
  end

  assign bus_io.intr    = intr_q;
  assign bus_io.int_id  = int_id_q;
  assign bus_io.pending = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller.
module tb_interrupt_controller;

  localparam int unsigned NumSrc = 4;
  localparam int unsigned IdW    = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   intr_cnt = 0;
  int   base;

  always #5 clk = ~clk;

  interrupt_controller_if #(.NUM_SRC(NumSrc), .ID_W(IdW)) bus ();

  interrupt_controller #(.NUM_SRC(NumSrc), .ID_W(IdW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always @(negedge clk) begin
    if (bus.intr === 1'b1) intr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.irq_in   = '0;
    bus.irq_mask = 4'b1111;
    bus.int_ack  = 1'b0;
    tick(3);
    check_eq("rst_pend", bus.pending, 4'b0000);
    check_eq("rst_intr", bus.intr, 1'b0);
    check_eq("rst_id", bus.int_id, 2'd0);
    tick();
    rst = 1'b0;
    tick(2);

    // Single edge on source 0
    bus.irq_in = 4'b0001;
    tick(3);
    check_eq("se_pend", bus.pending, 4'b0001);
    check_eq("se_intr_early", bus.intr, 1'b0);
    tick();
    check_eq("se_intr", bus.intr, 1'b1);
    check_eq("se_id", bus.int_id, 2'd0);
    tick();
    check_eq("se_intr_once", bus.intr, 1'b0);
    ack_pulse();
    check_eq("se_clr", bus.pending, 4'b0000);
    bus.irq_in = '0;
    tick(5);

    // Priority: sources 1 and 3 together
    bus.irq_in = 4'b1010;
    tick(3);
    check_eq("pr_pend", bus.pending, 4'b1010);
    tick();
    check_eq("pr_intr1", bus.intr, 1'b1);
    check_eq("pr_id1", bus.int_id, 2'd1);
    tick();
    ack_pulse();
    check_eq("pr_pend_mid", bus.pending, 4'b1000);
    tick();
    check_eq("pr_intr_clear", bus.intr, 1'b0);
    tick();
    check_eq("pr_intr2", bus.intr, 1'b1);
    check_eq("pr_id2", bus.int_id, 2'd3);
    tick();
    ack_pulse();
    check_eq("pr_clr", bus.pending, 4'b0000);
    bus.irq_in = '0;
    tick(5);

    // Masked source still records, serviced on unmask
    bus.irq_mask = 4'b1011;
    bus.irq_in   = 4'b0100;
    base         = intr_cnt;
    tick(3);
    check_eq("mk_pend", bus.pending, 4'b0100);
    tick(4);
    check_eq("mk_no_intr", intr_cnt - base, 0);
    bus.irq_mask = 4'b1111;
    tick();
    check_eq("mk_intr", bus.intr, 1'b1);
    check_eq("mk_id", bus.int_id, 2'd2);
    tick();
    ack_pulse();
    bus.irq_in = '0;
    tick(5);
    check_eq("mk_clr", bus.pending, 4'b0000);

    // New edge on source 0 coincident with its ack
    bus.irq_in = 4'b0001;
    tick(4);
    check_eq("co_intr1", bus.intr, 1'b1);
    bus.irq_in = '0;
    tick(4);
    bus.irq_in = 4'b0001;
    tick(2);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    check_eq("co_pend", bus.pending, 4'b0001);
    tick(2);
    check_eq("co_intr2", bus.intr, 1'b1);
    check_eq("co_id2", bus.int_id, 2'd0);
    tick();
    ack_pulse();
    check_eq("co_clr", bus.pending, 4'b0000);
    bus.irq_in = '0;
    tick(5);

    // Three edges on source 3 coalesce into one request
    base = intr_cnt;
    repeat (3) begin
      bus.irq_in = 4'b1000;
      tick(3);
      bus.irq_in = '0;
      tick(3);
    end
    tick(4);
    check_eq("cl_cnt", intr_cnt - base, 1);
    check_eq("cl_id", bus.int_id, 2'd3);
    check_eq("cl_pend", bus.pending, 4'b1000);
    ack_pulse();
    check_eq("cl_clr", bus.pending, 4'b0000);
    tick(6);
    check_eq("cl_cnt_after", intr_cnt - base, 1);

    // Ack ignored in ASSERT; reset mid-transaction; source held across release
    bus.irq_in = 4'b0110;
    tick(4);
    check_eq("rs_intr", bus.intr, 1'b1);
    check_eq("rs_id", bus.int_id, 2'd1);
    ack_pulse();
    check_eq("rs_ack_ignored", bus.pending, 4'b0110);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rs_pend", bus.pending, 4'b0000);
    check_eq("rs_intr0", bus.intr, 1'b0);
    check_eq("rs_id0", bus.int_id, 2'd0);
    tick();
    rst = 1'b0;
    tick(3);
    check_eq("rl_pend", bus.pending, 4'b0110);
    check_eq("rl_intr_early", bus.intr, 1'b0);
    tick();
    check_eq("rl_intr", bus.intr, 1'b1);
    check_eq("rl_id", bus.int_id, 2'd1);
    tick();
    ack_pulse();
    check_eq("rl_pend_mid", bus.pending, 4'b0100);
    tick(2);
    check_eq("rl_intr2", bus.intr, 1'b1);
    check_eq("rl_id2", bus.int_id, 2'd2);
    tick();
    ack_pulse();
    check_eq("rl_clr", bus.pending, 4'b0000);
    bus.irq_in = '0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter NUM_SRC, default 4, number of external interrupt sources (2..8).
REQ-002 Parameter ID_W, default 2, width of INT_ID, SHALL equal clog2(NUM_SRC).
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 IRQ_IN  input  NUM_SRC  raw asynchronous interrupt request levels, one per source.
REQ-006 IRQ_MASK  input  NUM_SRC  per-source enable, 1 = enabled; synchronous to CLK.
REQ-007 INT_ACK  input  1  CPU acknowledge pulse, one cycle, issued when vectoring to the ISR.
REQ-008 INTR  output  1  one-cycle interrupt request pulse, drives the set input of the CPU interrupt flag stage.
REQ-009 INT_ID  output  ID_W  index of the source currently being serviced.
REQ-010 PENDING  output  NUM_SRC  per-source pending flags, registered.

Function
REQ-011 Each IRQ_IN bit SHALL pass through a 2-flop synchronizer followed by a third flop for edge detection.
REQ-012 A synchronized 0->1 transition on source i SHALL set PENDING[i] on the next rising edge; levels held high SHALL NOT re-set it.
REQ-013 Latency: IRQ_IN[i] first sampled high at edge 1 -> PENDING[i]=1 after edge 3 -> INTR=1 for the cycle between edges 4 and 5, if idle and enabled.
REQ-014 FSM states: IDLE, ASSERT, WAIT_ACK, CLEAR.
REQ-015 IDLE: if (PENDING & IRQ_MASK) != 0, latch INT_ID = lowest-index set bit, go ASSERT; else stay.
REQ-016 ASSERT: INTR=1 for exactly one cycle, go WAIT_ACK.
REQ-017 WAIT_ACK: INTR=0; on INT_ACK=1 clear PENDING[INT_ID] and go CLEAR; otherwise stay indefinitely.
REQ-018 CLEAR: one idle cycle, go IDLE; guarantees the cleared flag is visible before re-arbitration.
REQ-019 INT_ID SHALL hold its value from IDLE->ASSERT until the next arbitration.
REQ-020 INT_ACK outside WAIT_ACK SHALL be ignored.
REQ-021 Simultaneous new edge on source INT_ID and its clear by INT_ACK: set wins, PENDING[INT_ID] stays 1.
REQ-022 Edges on other sources during ASSERT/WAIT_ACK/CLEAR SHALL set their PENDING bits and be serviced afterwards.
REQ-023 Masked sources SHALL still record PENDING; unmasking later SHALL cause service from IDLE.
REQ-024 Masking the serviced source during WAIT_ACK SHALL NOT abort the transaction.
REQ-025 Repeated edges on an already-pending source SHALL coalesce into one request.

Reset
REQ-026 RST=1 SHALL asynchronously force: FSM=IDLE, INTR=0, INT_ID=0, PENDING=0, all synchronizer and edge flops=0.
REQ-027 RST asserted mid-transaction SHALL discard all pending requests; the first edge after release SHALL follow REQ-013 latency.
REQ-028 A source held high across reset release SHALL register as a new edge (edge flop reset to 0).

Structure
REQ-029 FSM state enum and default NUM_SRC SHALL live in shared package intr_pkg.
REQ-030 One sub-module irq_sync_edge (per-bit synchronizer plus rising-edge detector, async reset) SHALL be instantiated NUM_SRC times.
REQ-031 Priority select SHALL be combinational in the top module; all outputs SHALL be registered.

Verification
REQ-032 Single edge: IRQ_IN=0001, mask=1111 -> INTR pulse on cycle 4, INT_ID=0; ACK -> PENDING=0000.
REQ-033 Priority: IRQ_IN 0000->1010 same cycle -> INT_ID=1 first; after ACK+CLEAR, second INTR with INT_ID=3.
REQ-034 Mask: mask=1011, edge on source 2 -> PENDING=0100, no INTR; mask=1111 -> INTR with INT_ID=2 next cycle after IDLE.
REQ-035 Collision: edge on source 0 same cycle as INT_ACK for source 0 -> PENDING[0]=1, second INTR issued.
REQ-036 Reset: RST pulsed during WAIT_ACK with PENDING=0110 -> PENDING=0000, INTR=0, INT_ID=0 immediately, before next clock.
REQ-037 Coalesce: three edges on source 3 before ACK -> exactly one INTR for INT_ID=3.
